reg_file_sb: RTL and testbench

Parametrised multi-read-port register file with synchronous reset, hardwired-zero register 0, same-cycle write-to-read bypass, and an integrated busy-bit scoreboard for pipelined cores.
- Decode marks a destination busy at issue, and writeback clears it.
- Each read port reports whether its operand is still pending, so the hazard unit can stall.
- It replaces the single-issue register file in the pipelined datapath and keeps the dedicated a0 output used by the testbench display.

---
 rtl/reg_file_sb_pkg.sv | 22 ++
 rtl/reg_file_sb_if.sv | 52 +++++
 rtl/reg_file_sb_scoreboard.sv | 72 +++++++
 rtl/reg_file_sb.sv | 105 ++++++++++
 tb/tb_reg_file_sb.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the scoreboarded register file: default widths,
// the architectural register indices the core cares about, and the common
// address/data typedefs.
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int XLEN     = 32;   // default register width
    localparam int REG_AW   = 5;    // default register index width
    localparam int REG_ZERO = 0;    // hardwired-zero register
    localparam int REG_A0   = 10;   // register mirrored on the a0 output

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    // Number of architectural registers for a given index width.
    function automatic int rf_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the read ports, writeback port, issue port and status outputs of
// the scoreboarded register file.
//
// Handshake: there is no valid/ready pair. WE and ISSUE_EN are qualifiers
// that the register file accepts unconditionally on every rising clock
// edge; reads (RD, RBUSY, a0) are combinational and valid whenever their
// inputs are stable.
//
// Signals:
//   RA       master->slave  read address per port
//   RD       slave->master  read data per port (bypass applied)
//   RBUSY    slave->master  operand of port i still pending
//   WE/WA/WD master->slave  writeback enable/address/data
//   ISSUE_EN master->slave  mark ISSUE_A busy
//   ISSUE_A  master->slave  destination being issued
//   BUSY_CNT slave->master  number of busy registers
//   a0       slave->master  contents of the a0 register (bypass applied)
// ---------------------------------------------------------------------------
interface reg_file_sb_if
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = REG_AW,
    parameter int DATA_WIDTH    = XLEN,
    parameter int NUM_READ      = 2
);

    logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] RA;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]    RD;
    logic [NUM_READ-1:0]                    RBUSY;
    logic                                   WE;
    logic [ADDRESS_WIDTH-1:0]               WA;
    logic [DATA_WIDTH-1:0]                  WD;
    logic                                   ISSUE_EN;
    logic [ADDRESS_WIDTH-1:0]               ISSUE_A;
    logic [ADDRESS_WIDTH:0]                 BUSY_CNT;
    logic [DATA_WIDTH-1:0]                  a0;

    // Pipeline side (decode / writeback / hazard unit).
    modport master (
        output RA, WE, WA, WD, ISSUE_EN, ISSUE_A,
        input  RD, RBUSY, BUSY_CNT, a0
    );

    // Register file side.
    modport slave (
        input  RA, WE, WA, WD, ISSUE_EN, ISSUE_A,
        output RD, RBUSY, BUSY_CNT, a0
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Busy-bit scoreboard: one bit per architectural register, set at issue and
// cleared at writeback, plus a registered count of busy registers.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   issue_en   mark issue_a busy at the next edge
//   issue_a    destination being issued
//   we, wa     writeback that clears wa at the next edge
//   ra         read addresses, one per read port
//   busy_lk    raw busy bit of each read port address (no bypass masking)
//   busy_cnt   number of busy registers
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = REG_AW,
    parameter int NUM_READ      = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   issue_en,
    input  logic [ADDRESS_WIDTH-1:0]               issue_a,
    input  logic                                   we,
    input  logic [ADDRESS_WIDTH-1:0]               wa,
    input  logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] ra,
    output logic [NUM_READ-1:0]                    busy_lk,
    output logic [ADDRESS_WIDTH:0]                 busy_cnt
);

    localparam int DEPTH = rf_depth(ADDRESS_WIDTH);
    localparam int CW    = ADDRESS_WIDTH + 1;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic             issue_ok;
    logic             set_event;
    logic             clear_event;

    always_comb begin
        // Register 0 can never become busy.
        issue_ok = issue_en && (issue_a != '0);
        set_vec  = issue_ok ? (DEPTH'(1) << issue_a) : '0;
        clr_vec  = we       ? (DEPTH'(1) << wa)      : '0;

        // Counter events mirror the bit transitions exactly, so the count
        // always equals popcount(busy): re-issuing a busy register is not a
        // new set, and a writeback that collides with an issue to the same
        // register is not a clear because the issue keeps the bit high.
        set_event   = issue_ok && !busy[issue_a];
        clear_event = we && busy[wa] && !(issue_ok && (issue_a == wa));

        for (int i = 0; i < NUM_READ; i++) begin
            busy_lk[i] = busy[ra[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // Set takes priority over clear: the newly issued producer
            // supersedes the one being written back.
            busy     <= set_vec | (busy & ~clr_vec);
            busy_cnt <= busy_cnt + CW'(set_event) - CW'(clear_event);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Multi-read-port register file with hardwired-zero register 0, same-cycle
// write-to-read bypass and an integrated busy-bit scoreboard.
//
// Ports:
//   CLK   clock; all state updates on the rising edge
//   RST   synchronous active-high reset (clears data, busy bits and count)
//   bus   reg_file_sb_if slave modport:
//           RA/RD/RBUSY        combinational read ports
//           WE/WA/WD           writeback
//           ISSUE_EN/ISSUE_A   destination issue
//           BUSY_CNT           number of busy registers
//           a0                 register A0_INDEX with bypass applied
// ---------------------------------------------------------------------------
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = REG_AW,
    parameter int DATA_WIDTH    = XLEN,
    parameter int NUM_READ      = 2,
    parameter int A0_INDEX      = REG_A0
) (
    input logic           CLK,
    input logic           RST,
    reg_file_sb_if.slave  bus
);

    localparam int DEPTH = rf_depth(ADDRESS_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);
    localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR   = ADDRESS_WIDTH'(A0_INDEX);

    logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] ra;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]    rd;
    logic [NUM_READ-1:0]                    rbusy;
    logic [NUM_READ-1:0]                    busy_lk;
    logic                                   we;
    logic [ADDRESS_WIDTH-1:0]               wa;
    logic [DATA_WIDTH-1:0]                  wd;
    logic [ADDRESS_WIDTH:0]                 busy_cnt;
    logic [DATA_WIDTH-1:0]                  a0_val;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign ra = bus.RA;
    assign we = bus.WE;
    assign wa = bus.WA;
    assign wd = bus.WD;

    // Read rule shared by every read port and a0: register 0 reads zero,
    // an in-flight writeback to the same address is forwarded, otherwise
    // the stored word is returned.
    function automatic logic [DATA_WIDTH-1:0] read_word(
        input logic [ADDRESS_WIDTH-1:0] addr
    );
        if (addr == ZERO_ADDR) begin
            return '0;
        end else if (we && (wa == addr)) begin
            return wd;
        end else begin
            return mem[addr];
        end
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != ZERO_ADDR)) begin
            mem[wa] <= wd;
        end
    end

    rf_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_READ      (NUM_READ)
    ) u_scoreboard (
        .clk      (CLK),
        .rst      (RST),
        .issue_en (bus.ISSUE_EN),
        .issue_a  (bus.ISSUE_A),
        .we       (we),
        .wa       (wa),
        .ra       (ra),
        .busy_lk  (busy_lk),
        .busy_cnt (busy_cnt)
    );

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            rd[i] = read_word(ra[i]);
            // A writeback in this very cycle already satisfies the read, so
            // the hazard unit must not stall on it.
            rbusy[i] = busy_lk[i] && !(we && (wa == ra[i]));
        end
        a0_val = read_word(A0_ADDR);
    end

    assign bus.RD       = rd;
    assign bus.RBUSY    = rbusy;
    assign bus.BUSY_CNT = busy_cnt;
    assign bus.a0       = a0_val;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Drives reg_file_sb one cycle at a time. For each cycle the driver computes
// the expected outputs from an array-based model of the register file and
// pushes them into exp_q; the monitor pops one entry per falling edge and
// compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
    import rf_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int A0    = 10;

    typedef struct packed {
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic [1:0]    rbusy;
        logic [AW:0]   cnt;
        logic [DW-1:0] a0;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_READ      (NR)
    ) bus ();

    reg_file_sb #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_READ      (NR),
        .A0_INDEX      (A0)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [DW-1:0] m_read(input int a, input bit we,
                                             input int wa, input logic [DW-1:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return m_mem[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit r, input bit we, input int wa,
                               input logic [DW-1:0] wd, input bit ie,
                               input int ia, input int r0, input int r1);
        exp_t e;
        int   cnt;
        @(posedge clk);
        #1;
        rst          = r;
        bus.WE       = we;
        bus.WA       = AW'(wa);
        bus.WD       = wd;
        bus.ISSUE_EN = ie;
        bus.ISSUE_A  = AW'(ia);
        bus.RA[0]    = AW'(r0);
        bus.RA[1]    = AW'(r1);

        cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt += int'(m_busy[i]);
        e.rd0      = m_read(r0, we, wa, wd);
        e.rd1      = m_read(r1, we, wa, wd);
        e.rbusy[0] = m_busy[r0] && !(we && wa == r0);
        e.rbusy[1] = m_busy[r1] && !(we && wa == r1);
        e.cnt      = (AW+1)'(cnt);
        e.a0       = m_read(A0, we, wa, wd);
        exp_q.push_back(e);

        // State after the coming edge.
        if (r) begin
            m_reset();
        end else begin
            if (we && wa != 0) m_mem[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (ie && ia != 0) m_busy[ia] = 1'b1;   // issue overrides writeback
        end
    endtask

    task automatic idle(input int r0, input int r1);
        drive_cycle(0, 0, 0, '0, 0, 0, r0, r1);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string nm, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd0",      bus.RD[0],               e.rd0);
            check("rd1",      bus.RD[1],               e.rd1);
            check("rbusy",    DW'(bus.RBUSY),          DW'(e.rbusy));
            check("busy_cnt", DW'(bus.BUSY_CNT),       DW'(e.cnt));
            check("a0",       bus.a0,                  e.a0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        bus.WE       = 1'b0;
        bus.WA       = '0;
        bus.WD       = '0;
        bus.ISSUE_EN = 1'b0;
        bus.ISSUE_A  = '0;
        bus.RA       = '0;
        m_reset();
        repeat (2) @(posedge clk);

        // Reset then read every address on both ports.
        for (int a = 0; a < 16; a++) idle(a, a + 16);

        // Write with same-cycle bypass, then through storage.
        drive_cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        idle(5, 0);

        // Register zero: writes ignored, issue ignored.
        drive_cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 5);
        drive_cycle(0, 0, 0, '0, 1, 0, 0, 0);
        idle(0, 0);

        // Scoreboard set / re-issue / clear with bypass.
        drive_cycle(0, 0, 0, '0, 1, 3, 3, 0);
        drive_cycle(0, 0, 0, '0, 1, 3, 3, 0);
        drive_cycle(0, 1, 3, 32'd7, 0, 0, 3, 3);
        idle(3, 0);

        // Issue/writeback collision on a busy register.
        drive_cycle(0, 0, 0, '0, 1, 4, 4, 0);
        drive_cycle(0, 1, 4, 32'h0000_0099, 1, 4, 4, 0);
        idle(4, 0);
        // Writeback to a non-busy register.
        drive_cycle(0, 1, 9, 32'h1234_5678, 0, 0, 9, 4);
        idle(9, 4);

        // a0 and reset mid-flight.
        drive_cycle(0, 1, 10, 32'd42, 0, 0, 10, 0);
        idle(10, 0);
        drive_cycle(0, 0, 0, '0, 1, 6, 6, 7);
        drive_cycle(0, 0, 0, '0, 1, 7, 6, 7);
        drive_cycle(1, 1, 8, 32'hAAAA_5555, 1, 9, 6, 7);
        idle(6, 7);
        for (int a = 0; a < 16; a++) idle(a, a + 16);

        // Randomised traffic, biased towards a few registers to provoke
        // collisions, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            int hi;
            hi = ($urandom_range(0, 1) == 0) ? 7 : DEPTH - 1;
            drive_cycle($urandom_range(0, 299) == 0,
                        $urandom_range(0, 1) == 1,
                        int'($urandom_range(0, hi)),
                        $urandom(),
                        $urandom_range(0, 9) < 4,
                        int'($urandom_range(0, hi)),
                        int'($urandom_range(0, hi)),
                        int'($urandom_range(0, DEPTH - 1)));
        end

        idle(0, 0);
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
